gpio_irq_wb8: RTL and testbench

GPIO_IRQ_WB8 -- requirements
Module: gpio_irq_wb8

---
 rtl/gpio_irq_wb8.sv | 117 +++++++++++
 tb/tb_gpio_irq_wb8.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/gpio_irq_wb8.sv
// Eight-pin GPIO input block with per-pin debounce, edge-selectable interrupt
// capture and an 8-bit Wishbone-style register interface.
module gpio_irq_wb8 #(
    parameter int DEBOUNCE = 16
) (
    input  logic       I_wb_clk,
    input  logic       I_reset,
    input  logic [1:0] I_wb_adr,
    input  logic [7:0] I_wb_dat,
    input  logic       I_wb_stb,
    input  logic       I_wb_we,
    output logic       O_wb_ack,
    output logic [7:0] O_wb_dat,
    input  logic [7:0] I_pins,
    output logic       O_irq
);

    localparam int CW = $clog2(DEBOUNCE);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE - 1);

    logic [7:0]    s1, s2;
    logic [7:0]    db, db_next;
    logic [CW-1:0] cnt [8];
    logic [CW-1:0] cnt_next [8];
    logic [7:0]    enable, edge_sel, pending;
    logic [7:0]    pend_set, pend_clr;
    logic [7:0]    rd_mux;
    logic          bus_wr, bus_rd;

    assign bus_wr = I_wb_stb & I_wb_we;
    assign bus_rd = I_wb_stb & ~I_wb_we;

    always_ff @(posedge I_wb_clk) begin
        if (I_reset) begin
            s1 <= 8'h00;
            s2 <= 8'h00;
        end else begin
            s1 <= I_pins;
            s2 <= s1;
        end
    end

    // A counter only advances while the synchronized pin disagrees with db;
    // it saturates at DEBOUNCE-1, where the next disagreeing edge commits.
    always_comb begin
        for (int i = 0; i < 8; i++) begin
            db_next[i]  = db[i];
            cnt_next[i] = '0;
            if (s2[i] != db[i]) begin
                if (cnt[i] == CNT_MAX) begin
                    db_next[i] = s2[i];
                end else begin
                    cnt_next[i] = cnt[i] + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge I_wb_clk) begin
        if (I_reset) begin
            db <= 8'h00;
            for (int i = 0; i < 8; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            db <= db_next;
            for (int i = 0; i < 8; i++) begin
                cnt[i] <= cnt_next[i];
            end
        end
    end

    assign pend_set = (db_next & ~db & ~edge_sel) | (~db_next & db & edge_sel);
    assign pend_clr = (bus_wr && (I_wb_adr == 2'd3)) ? I_wb_dat : 8'h00;

    // The set term is OR-ed in after the clear so a new event is never lost.
    always_ff @(posedge I_wb_clk) begin
        if (I_reset) begin
            enable   <= 8'h00;
            edge_sel <= 8'h00;
            pending  <= 8'h00;
        end else begin
            if (bus_wr) begin
                case (I_wb_adr)
                    2'd1:    enable   <= I_wb_dat;
                    2'd2:    edge_sel <= I_wb_dat;
                    default: ;
                endcase
            end
            pending <= (pending & ~pend_clr) | pend_set;
        end
    end

    always_comb begin
        case (I_wb_adr)
            2'd0:    rd_mux = db;
            2'd1:    rd_mux = enable;
            2'd2:    rd_mux = edge_sel;
            default: rd_mux = pending;
        endcase
    end

    always_ff @(posedge I_wb_clk) begin
        if (I_reset) begin
            O_wb_ack <= 1'b0;
            O_wb_dat <= 8'h00;
        end else begin
            O_wb_ack <= I_wb_stb;
            if (bus_rd) begin
                O_wb_dat <= rd_mux;
            end
        end
    end

    assign O_irq = |(pending & enable);

endmodule

// File: tb/tb_gpio_irq_wb8.sv
// Self-checking bench for gpio_irq_wb8: directed scenarios plus randomized
// traffic, all compared against a sample-history reference model.
module tb_gpio_irq_wb8;

    localparam int DB = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic [1:0] adr;
    logic [7:0] wdat;
    logic       stb;
    logic       we;
    logic       ack;
    logic [7:0] rdat;
    logic [7:0] pins;
    logic       irq;

    int n_vec = 0;
    int n_err = 0;

    // Reference model state
    logic [7:0] m_db, m_en, m_es, m_pend, m_rdat;
    logic       m_ack;
    logic [7:0] hist [0:DB];

    always #5 clk = ~clk;

    gpio_irq_wb8 #(.DEBOUNCE(DB)) dut (
        .I_wb_clk(clk),
        .I_reset (reset),
        .I_wb_adr(adr),
        .I_wb_dat(wdat),
        .I_wb_stb(stb),
        .I_wb_we (we),
        .O_wb_ack(ack),
        .O_wb_dat(rdat),
        .I_pins  (pins),
        .O_irq   (irq)
    );

    function automatic logic m_irq();
        return |(m_pend & m_en);
    endfunction

    // hist[k] holds the pins seen k+1 edges ago, so hist[1..DB] are the last DB
    // synchronized samples; a pin flips once all of them disagree with db.
    task automatic tick();
        logic [7:0] p, f, dn, sm, cm, wd;
        logic       rs, st, w;
        logic [1:0] a;
        p = pins; rs = reset; st = stb; w = we; a = adr; wd = wdat;
        @(posedge clk);
        if (rs) begin
            m_db = 0; m_en = 0; m_es = 0; m_pend = 0; m_rdat = 0; m_ack = 0;
            for (int k = 0; k <= DB; k++) hist[k] = 8'h00;
        end else begin
            f = 8'hFF;
            for (int k = 1; k <= DB; k++) f = f & (hist[k] ^ m_db);
            dn = m_db ^ f;
            sm = (f & dn & ~m_es) | (f & m_db & m_es);
            cm = 8'h00;
            m_ack = st;
            if (st && !w) begin
                case (a)
                    2'd0: m_rdat = m_db;
                    2'd1: m_rdat = m_en;
                    2'd2: m_rdat = m_es;
                    default: m_rdat = m_pend;
                endcase
            end else if (st && w) begin
                case (a)
                    2'd1: m_en = wd;
                    2'd2: m_es = wd;
                    2'd3: cm = wd;
                    default: ;
                endcase
            end
            m_pend = (m_pend & ~cm) | sm;
            m_db = dn;
            for (int k = DB; k >= 1; k--) hist[k] = hist[k-1];
            hist[0] = p;
        end
        #1;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) tick();
    endtask

    task automatic bus_write(input logic [1:0] a, input logic [7:0] d);
        adr = a; wdat = d; we = 1'b1; stb = 1'b1;
        tick();
        stb = 1'b0; we = 1'b0;
    endtask

    task automatic bus_read(input logic [1:0] a);
        adr = a; we = 1'b0; stb = 1'b1;
        tick();
        stb = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; pins = 8'h00; stb = 1'b1; we = 1'b1; adr = 2'd1; wdat = 8'hFF;
        idle(2);
        reset = 1'b0; stb = 1'b0; we = 1'b0;
        n_vec++; if (ack !== 1'b0) begin n_err++; $display("[TB] FAIL reset_ack got %b want 0", ack); end
        n_vec++; if (irq !== 1'b0) begin n_err++; $display("[TB] FAIL reset_irq got %b want 0", irq); end
        n_vec++; if (rdat !== 8'h00) begin n_err++; $display("[TB] FAIL reset_rdat got %h want 00", rdat); end
        for (int a = 0; a < 4; a++) begin
            bus_read(2'(a));
            n_vec++; if (rdat !== 8'h00) begin n_err++; $display("[TB] FAIL reset_reg adr=%0d got %h want 00", a, rdat); end
            n_vec++; if (ack !== 1'b1) begin n_err++; $display("[TB] FAIL reset_read_ack adr=%0d got %b want 1", a, ack); end
        end
    endtask

    task automatic test_rise_pin0();
        bus_write(2'd2, 8'h00);
        bus_write(2'd1, 8'h01);
        idle(2);
        pins = 8'h01;
        for (int k = 1; k <= 6; k++) begin
            tick();
            n_vec++; if (irq !== (k == 6)) begin n_err++; $display("[TB] FAIL rise_irq edge=%0d got %b want %b", k, irq, (k == 6)); end
            n_vec++; if (irq !== m_irq()) begin n_err++; $display("[TB] FAIL rise_irq_model edge=%0d got %b want %b", k, irq, m_irq()); end
        end
        bus_read(2'd0);
        n_vec++; if (rdat !== 8'h01) begin n_err++; $display("[TB] FAIL rise_db got %h want 01", rdat); end
        bus_read(2'd3);
        n_vec++; if (rdat !== 8'h01) begin n_err++; $display("[TB] FAIL rise_pending got %h want 01", rdat); end
        bus_write(2'd3, 8'h01);
        n_vec++; if (irq !== 1'b0) begin n_err++; $display("[TB] FAIL rise_clear_irq got %b want 0", irq); end
        bus_write(2'd1, 8'h00);
    endtask

    task automatic test_glitch();
        bus_write(2'd1, 8'h08);
        pins = 8'h09; adr = 2'd0; we = 1'b0; stb = 1'b1;
        for (int k = 0; k < 12; k++) begin
            if (k == 3) pins = 8'h01;
            tick();
            n_vec++; if (rdat !== 8'h01) begin n_err++; $display("[TB] FAIL glitch_db k=%0d got %h want 01", k, rdat); end
            n_vec++; if (ack !== 1'b1) begin n_err++; $display("[TB] FAIL glitch_ack k=%0d got %b want 1", k, ack); end
            n_vec++; if (irq !== 1'b0) begin n_err++; $display("[TB] FAIL glitch_irq k=%0d got %b want 0", k, irq); end
        end
        stb = 1'b0;
        bus_read(2'd3);
        n_vec++; if (rdat !== 8'h00) begin n_err++; $display("[TB] FAIL glitch_pending got %h want 00", rdat); end
        bus_write(2'd1, 8'h00);
    endtask

    task automatic test_falling_pin7();
        bus_write(2'd2, 8'h80);
        pins = 8'h81;
        idle(8);
        bus_read(2'd3);
        n_vec++; if (rdat !== 8'h00) begin n_err++; $display("[TB] FAIL fall_rise_ignored got %h want 00", rdat); end
        pins = 8'h01;
        idle(6);
        bus_read(2'd3);
        n_vec++; if (rdat !== 8'h80) begin n_err++; $display("[TB] FAIL fall_pending got %h want 80", rdat); end
        n_vec++; if (irq !== 1'b0) begin n_err++; $display("[TB] FAIL fall_irq_masked got %b want 0", irq); end
        bus_write(2'd1, 8'h80);
        n_vec++; if (irq !== 1'b1) begin n_err++; $display("[TB] FAIL fall_irq_enabled got %b want 1", irq); end
        bus_write(2'd3, 8'h80);
        n_vec++; if (irq !== 1'b0) begin n_err++; $display("[TB] FAIL fall_irq_cleared got %b want 0", irq); end
        bus_read(2'd3);
        n_vec++; if (rdat !== 8'h00) begin n_err++; $display("[TB] FAIL fall_pending_cleared got %h want 00", rdat); end
        bus_write(2'd1, 8'h00);
        bus_write(2'd2, 8'h00);
    endtask

    task automatic test_set_clear_collision();
        bus_write(2'd1, 8'h04);
        pins = 8'h05;
        idle(5);
        n_vec++; if (irq !== 1'b0) begin n_err++; $display("[TB] FAIL collide_early_irq got %b want 0", irq); end
        bus_write(2'd3, 8'h04);
        n_vec++; if (irq !== 1'b1) begin n_err++; $display("[TB] FAIL collide_irq got %b want 1", irq); end
        bus_read(2'd3);
        n_vec++; if (rdat !== 8'h04) begin n_err++; $display("[TB] FAIL collide_pending got %h want 04", rdat); end
        bus_write(2'd3, 8'h04);
        bus_write(2'd1, 8'h00);
    endtask

    task automatic test_bus();
        bus_write(2'd1, 8'h5A);
        bus_read(2'd1);
        n_vec++; if (ack !== 1'b1) begin n_err++; $display("[TB] FAIL bus_ack got %b want 1", ack); end
        n_vec++; if (rdat !== 8'h5A) begin n_err++; $display("[TB] FAIL bus_rdat got %h want 5a", rdat); end
        tick();
        n_vec++; if (ack !== 1'b0) begin n_err++; $display("[TB] FAIL bus_ack_drop got %b want 0", ack); end
        n_vec++; if (rdat !== 8'h5A) begin n_err++; $display("[TB] FAIL bus_rdat_hold got %h want 5a", rdat); end
        bus_write(2'd0, 8'hFF);
        bus_read(2'd0);
        n_vec++; if (rdat !== 8'h05) begin n_err++; $display("[TB] FAIL bus_db_readonly got %h want 05", rdat); end
        n_vec++; if (rdat !== m_rdat) begin n_err++; $display("[TB] FAIL bus_db_model got %h want %h", rdat, m_rdat); end
        bus_write(2'd1, 8'h00);
    endtask

    task automatic test_reset_mid_debounce();
        logic [1:0] addrs [8];
        logic [7:0] exps  [8];
        addrs = '{2'd3, 2'd2, 2'd1, 2'd0, 2'd0, 2'd0, 2'd0, 2'd3};
        exps  = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'hFF, 8'hFF};
        pins = 8'h00;
        idle(8);
        bus_write(2'd2, 8'h3C);
        bus_write(2'd1, 8'hC3);
        pins = 8'hFF;
        idle(4);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        for (int k = 0; k < 8; k++) begin
            adr = addrs[k]; we = 1'b0; stb = 1'b1;
            tick();
            n_vec++; if (rdat !== exps[k]) begin n_err++; $display("[TB] FAIL rstmid_read edge=%0d adr=%0d got %h want %h", k + 1, addrs[k], rdat, exps[k]); end
            n_vec++; if (rdat !== m_rdat) begin n_err++; $display("[TB] FAIL rstmid_model edge=%0d got %h want %h", k + 1, rdat, m_rdat); end
            n_vec++; if (irq !== 1'b0) begin n_err++; $display("[TB] FAIL rstmid_irq edge=%0d got %b want 0", k + 1, irq); end
        end
        stb = 1'b0;
        bus_write(2'd3, 8'hFF);
    endtask

    task automatic test_random();
        for (int k = 0; k < 500; k++) begin
            reset = ($urandom_range(0, 99) == 0);
            pins  = pins ^ 8'($urandom & $urandom & $urandom);
            stb   = 1'($urandom_range(0, 1));
            we    = 1'($urandom_range(0, 1));
            adr   = 2'($urandom_range(0, 3));
            wdat  = 8'($urandom);
            tick();
            n_vec++; if (ack !== m_ack) begin n_err++; $display("[TB] FAIL rand_ack cyc=%0d got %b want %b", k, ack, m_ack); end
            n_vec++; if (rdat !== m_rdat) begin n_err++; $display("[TB] FAIL rand_rdat cyc=%0d got %h want %h", k, rdat, m_rdat); end
            n_vec++; if (irq !== m_irq()) begin n_err++; $display("[TB] FAIL rand_irq cyc=%0d got %b want %b", k, irq, m_irq()); end
        end
        reset = 1'b0; stb = 1'b0; we = 1'b0;
    endtask

    initial begin
        reset = 1'b1; adr = 2'd0; wdat = 8'h00; stb = 1'b0; we = 1'b0; pins = 8'h00;
        m_db = 0; m_en = 0; m_es = 0; m_pend = 0; m_rdat = 0; m_ack = 0;
        for (int k = 0; k <= DB; k++) hist[k] = 8'h00;
        $display("[TB] starting gpio_irq_wb8 bench, DEBOUNCE=%0d", DB);
        test_reset();
        test_rise_pin0();
        test_glitch();
        test_falling_pin7();
        test_set_clear_collision();
        test_bus();
        test_reset_mid_debounce();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
